// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader: FSM state
//   encoding, byte-packer index width and checksum width.
//   Build option: IMEM_LOADER_CHECKSUM_EN adds the CSUM state (trailing
//   XOR byte after the payload).
package imem_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_FIN,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam int WORD_W     = 32;  // packer is fixed at 4 bytes
    localparam int BYTE_IDX_W = 2;   // byte position within a word
    localparam int CSUM_W     = 8;   // running XOR of payload bytes

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer
//   Assembles little-endian 32-bit words from a byte stream. Each pushed
//   byte enters at the top and shifts down, so after four pushes the first
//   byte sits in bits [7:0].
//   Ports: clk, rstn (async active-low), clear (restart at byte 0),
//          push (accept byte_in), byte_in[7:0],
//          word[31:0] (shift register), word_full (pulse with the 4th push).
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [BYTE_IDX_W-1:0] byte_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (push) begin
            word     <= {byte_in, word[WORD_W-1:8]};
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign word_full = push && (byte_idx == '1);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction-memory programmer. Stream format: LEN lo, LEN hi,
//   then LEN*4 payload bytes (little-endian words), optionally followed by a
//   XOR checksum byte. Words are written to imem at consecutive indices
//   starting at 0. cpu_hold stays high until a full image has been loaded.
//   Build option: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte checked).
//   Ports:
//     clk, rstn             clock, async active-low reset
//     en                    enable; low freezes all state and handshakes
//     start                 pulse, begins a load from IDLE/DONE/ERR
//     byte_in/valid/ready   byte stream handshake
//     imem_a/imem_wd/imem_we  imem write port
//     cpu_hold, done, error status
//     word_count            words written in the current load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,  // only 32 is meaningful with the 4-byte packer
    parameter int MEM_CAPACITY = 10,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] imem_a,
    output logic [DATA_WIDTH-1:0] imem_wd,
    output logic                  imem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  word_count
);

    localparam logic [LEN_WIDTH-1:0] CAP = LEN_WIDTH'(MEM_CAPACITY);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t               state, state_nx;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_full;
    logic [WORD_W-1:0]    word;
    logic                 word_full;
    logic                 accept;
    logic                 start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]    csum;
`endif

    assign accept   = byte_valid && byte_ready;  // byte_ready already includes en
    assign start_ok = en && start &&
                      (state == S_IDLE || state == S_DONE || state == S_ERR);
    // Full length as it becomes known on the high header byte.
    assign len_full = LEN_WIDTH'({byte_in, len[7:0]});

    byte_word_packer u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (start_ok),
        .push      (accept && state == S_DATA),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            len        <= '0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state <= state_nx;
            if (start_ok) begin
                len        <= '0;
                word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end else if (en) begin
                if (accept && state == S_LEN_LO) len <= LEN_WIDTH'(byte_in);
                if (accept && state == S_LEN_HI) len <= len_full;
                if (state == S_WRITE)            word_count <= word_count + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept && state == S_DATA)   csum <= csum ^ byte_in;
`endif
            end
        end
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        done       = (state == S_DONE);
        error      = (state == S_ERR);
        cpu_hold   = (state != S_DONE);
        if (start_ok) begin
            state_nx = S_LEN_LO;
        end else if (en) begin
            case (state)
                S_LEN_LO: begin
                    byte_ready = 1'b1;
                    if (accept) state_nx = S_LEN_HI;
                end
                S_LEN_HI: begin
                    byte_ready = 1'b1;
                    if (accept)
                        state_nx = (len_full > CAP) ? S_ERR :
                                   (len_full == '0) ? S_FIN : S_DATA;
                end
                S_DATA: begin
                    byte_ready = 1'b1;
                    if (word_full) state_nx = S_WRITE;
                end
                S_WRITE: begin
                    imem_we  = 1'b1;
                    state_nx = (word_count + ONE == len) ? S_FIN : S_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_FIN: state_nx = S_CSUM;
                S_CSUM: begin
                    byte_ready = 1'b1;
                    if (accept) state_nx = (byte_in == csum) ? S_DONE : S_ERR;
                end
`else
                S_FIN: state_nx = S_DONE;
`endif
                default: ;
            endcase
        end
    end

    // Address is the current word count; both stay put through the WRITE cycle.
    assign imem_a  = DATA_WIDTH'(word_count);
    assign imem_wd = DATA_WIDTH'(word);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed + randomized bench for imem_loader. The reference model derives
//   the expected imem writes and final status from the image (length, words,
//   checksum) alone; observed writes are collected at the negative edge.
module tb_imem_loader;

    localparam int CAP = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] imem_a;
    logic [31:0] imem_wd;
    logic        imem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] wr_q[$];

    imem_loader #(.DATA_WIDTH(32), .MEM_CAPACITY(CAP), .LEN_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .en(en), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_a(imem_a), .imem_wd(imem_wd), .imem_we(imem_we),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back({imem_a, imem_wd});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte with random valid gaps; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        int t = 0;
        while (!acc) begin
            if (t > 200) begin
                chk("byte_timeout", 1'b0, 1'b1);
                byte_valid = 1'b0;
                return;
            end
            byte_in    = b;
            byte_valid = ($urandom_range(0, 3) != 0);
            acc        = byte_valid && byte_ready;
            @(negedge clk);
            t++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("end_timeout", done || error, 1'b1);
    endtask

    // Mid-word stall: en low for 5 cycles with data offered and a start pulse
    // that must be ignored; then a start pulse in DATA that must also be ignored.
    task automatic freeze();
        logic [15:0] wc0 = word_count;
        for (int c = 0; c < 5; c++) begin
            en         = 1'b0;
            byte_valid = 1'b1;
            start      = (c == 2);
            @(negedge clk);
            chk("frz_ready", byte_ready, 1'b0);
            chk("frz_we", imem_we, 1'b0);
            chk("frz_wc", word_count, wc0);
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        en         = 1'b1;
        pulse_start();
        chk("busy_hold", cpu_hold, 1'b1);
    endtask

    // Send a full image and compare results against the model.
    task automatic run_load(input string tag, input int len, input logic [31:0] words[$],
                            input bit bad_csum, input int freeze_at);
        bit        ok = (len <= CAP);
        logic [7:0] x = 8'h00;
        logic [7:0] bt;
        logic [15:0] l16 = 16'(len);
        int        k = 0;
        int        n_exp;
        wr_q.delete();
        pulse_start();
        send_byte(l16[7:0]);
        send_byte(l16[15:8]);
        if (ok) begin
            for (int w = 0; w < len; w++)
                for (int b = 0; b < 4; b++) begin
                    if (k == freeze_at) freeze();
                    bt = words[w][8*b +: 8];
                    x  = x ^ bt;
                    send_byte(bt);
                    k++;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(x ^ {7'd0, bad_csum});
            if (bad_csum) ok = 1'b0;
`endif
        end
        wait_end();
        n_exp = (len <= CAP) ? len : 0;
        chk({tag, "_done"}, done, ok);
        chk({tag, "_error"}, error, !ok);
        chk({tag, "_hold"}, cpu_hold, !ok);
        chk({tag, "_wc"}, word_count, 16'(n_exp));
        chk({tag, "_nwr"}, wr_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_q.size(); i++)
            chk({tag, "_wr"}, wr_q[i], {32'(i), words[i]});
    endtask

    initial begin
        logic [31:0] q[$];
        int len;

        // Reset state
        #1 rstn = 1'b0;
        #1;
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_a", imem_a, 32'h0);
        chk("rst_wd", imem_wd, 32'h0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_wc", word_count, 16'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_ready", byte_ready, 1'b0);

        // Two known words
        q = {32'h12345678, 32'hDEADBEEF};
        run_load("t1", 2, q, 1'b0, -1);

        // Oversized image: rejected after the header
        q.delete();
        run_load("t2", CAP + 1, q, 1'b0, -1);

        // Empty image
        run_load("t3", 0, q, 1'b0, -1);

        // Stall mid-word, ignored start pulses
        q = {32'hA5A55A5A, 32'h0BADF00D};
        run_load("t4", 2, q, 1'b0, 5);

        // Full-capacity image
        q.delete();
        for (int i = 0; i < CAP; i++) q.push_back($urandom);
        run_load("cap", CAP, q, 1'b0, -1);

        // Reset during second word
        q = {32'h11111111, 32'h22222222, 32'h33333333};
        pulse_start();
        send_byte(8'd3);
        send_byte(8'd0);
        for (int b = 0; b < 6; b++) send_byte(8'h40 + 8'(b));
        #2 rstn = 1'b0;
        #1;
        chk("mrst_ready", byte_ready, 1'b0);
        chk("mrst_we", imem_we, 1'b0);
        chk("mrst_a", imem_a, 32'h0);
        chk("mrst_wd", imem_wd, 32'h0);
        chk("mrst_hold", cpu_hold, 1'b1);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", error, 1'b0);
        chk("mrst_wc", word_count, 16'h0);
        @(negedge clk);
        rstn = 1'b1;
        run_load("t5", 3, q, 1'b0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        q = {32'h04030201};
        run_load("t6_ok", 1, q, 1'b0, -1);
        run_load("t6_bad", 1, q, 1'b1, -1);
`endif

        // Randomized images, including oversized lengths
        for (int r = 0; r < 8; r++) begin
            q.delete();
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(CAP + 1, 65535))
                                              : int'($urandom_range(0, CAP));
            if (len <= CAP)
                for (int i = 0; i < len; i++) q.push_back($urandom);
            run_load("rnd", len, q, $urandom_range(0, 3) == 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
